w450_mem_responder: RTL and testbench

- Memory-side responder for the w450 8-bit processor. Serves two asynchronous read ports (instruction fetch and r0-indirect) and one synchronous write port.
- Owns program bring-up: after reset it clears memory, then accepts a program byte stream over a valid/ready loader interface, then releases the CPU from reset.
- Counts processor writes for bench and debug visibility.

---
 rtl/w450_mem_responder.sv | 141 ++++++++++++++
 tb/tb_w450_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/w450_mem_responder.sv
// Memory responder for the w450 CPU: clears memory, loads a program, then runs.
// Optional write-to-read forwarding under W450_MEM_WR_BYPASS_EN.
module w450_mem_responder #(
  parameter int N     = 8,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] mem_rd_addr1,
  output logic [N-1:0] mem_rd_data1,
  input  logic [N-1:0] mem_rd_addr2,
  output logic [N-1:0] mem_rd_data2,
  input  logic [N-1:0] mem_wr_addr,
  input  logic [N-1:0] mem_wr_data,
  input  logic         mem_wr_en,
  input  logic         ld_valid,
  input  logic [N-1:0] ld_data,
  input  logic         ld_last,
  output logic         ld_ready,
  output logic         cpu_reset,
  output logic         load_done,
  output logic [N:0]   ld_count,
  output logic [15:0]  wr_count
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_LOAD,
    S_FLUSH,
    S_RUN
  } state_e;

  localparam logic [N-1:0] LAST = N'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  clr_ptr_q, clr_ptr_d;
  logic [N-1:0]  ld_ptr_q, ld_ptr_d;
  logic [N:0]    ld_count_q, ld_count_d;
  logic [15:0]   wr_count_q, wr_count_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          load_done_q, load_done_d;

  logic [N-1:0]  mem_q [DEPTH];
  logic          we;
  logic [N-1:0]  waddr;
  logic [N-1:0]  wdata;

  // Next-state, counters and the single shared memory write port.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ld_ptr_d   = ld_ptr_q;
    ld_count_d = ld_count_q;
    wr_count_d = wr_count_q;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    unique case (state_q)
      S_CLEAR: begin
        we        = 1'b1;
        waddr     = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (ld_valid) begin
          we         = 1'b1;
          waddr      = ld_ptr_q;
          wdata      = ld_data;
          ld_count_d = ld_count_q + 1'b1;
          if (ld_last || ld_ptr_q == LAST) begin
            state_d = S_FLUSH;
          end else begin
            ld_ptr_d = ld_ptr_q + 1'b1;
          end
        end
      end
      S_FLUSH: state_d = S_RUN;
      S_RUN: begin
        if (mem_wr_en) begin
          we    = 1'b1;
          waddr = mem_wr_addr;
          wdata = mem_wr_data;
          if (wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
    cpu_reset_d = (state_d != S_RUN);
    load_done_d = (state_d == S_RUN);
  end

  // Control state and counters with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      clr_ptr_q   <= '0;
      ld_ptr_q    <= '0;
      ld_count_q  <= '0;
      wr_count_q  <= '0;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ld_ptr_q    <= ld_ptr_d;
      ld_count_q  <= ld_count_d;
      wr_count_q  <= wr_count_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
    end
  end

  // Storage array; contents are initialised by the CLEAR sweep, not by reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Asynchronous read ports, gated to zero until the CPU runs.
  always_comb begin
    mem_rd_data1 = '0;
    mem_rd_data2 = '0;
    if (state_q == S_RUN) begin
      mem_rd_data1 = mem_q[mem_rd_addr1];
      mem_rd_data2 = mem_q[mem_rd_addr2];
`ifdef W450_MEM_WR_BYPASS_EN
      if (mem_wr_en && mem_wr_addr == mem_rd_addr1) mem_rd_data1 = mem_wr_data;
      if (mem_wr_en && mem_wr_addr == mem_rd_addr2) mem_rd_data2 = mem_wr_data;
`endif
    end
  end

  assign ld_ready  = (state_q == S_LOAD);
  assign cpu_reset = cpu_reset_q;
  assign load_done = load_done_q;
  assign ld_count  = ld_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_w450_mem_responder.sv
// Directed bench for w450_mem_responder: bring-up, load, run-time access.
// Expected values are hand-computed; bypass expectations follow the same macro.
module tb_w450_mem_responder;

`ifdef W450_MEM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  mem_rd_addr1 = '0;
  logic [7:0]  mem_rd_data1;
  logic [7:0]  mem_rd_addr2 = '0;
  logic [7:0]  mem_rd_data2;
  logic [7:0]  mem_wr_addr = '0;
  logic [7:0]  mem_wr_data = '0;
  logic        mem_wr_en = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        cpu_reset;
  logic        load_done;
  logic [8:0]  ld_count;
  logic [15:0] wr_count;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  w450_mem_responder dut (
    .clk(clk),
    .reset(reset),
    .mem_rd_addr1(mem_rd_addr1),
    .mem_rd_data1(mem_rd_data1),
    .mem_rd_addr2(mem_rd_addr2),
    .mem_rd_data2(mem_rd_data2),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .ld_ready(ld_ready),
    .cpu_reset(cpu_reset),
    .load_done(load_done),
    .ld_count(ld_count),
    .wr_count(wr_count)
  );

  typedef struct {
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic        we;
    logic [7:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic [15:0] ewc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Waits for ld_ready; returns edges counted, flags bad cpu_reset/read data.
  task automatic wait_load(output int n, output bit bad);
    n = 0;
    bad = 1'b0;
    while (!ld_ready && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (!ld_ready && (cpu_reset !== 1'b1 || mem_rd_data1 !== 8'h00))
        bad = 1'b1;
      mem_rd_addr1 = mem_rd_addr1 + 8'd1;
    end
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int  n;
    bit  bad;

    tbl[0] = '{8'd0,   8'd1,   1'b0, 8'd0,   8'h00, 8'hA0, 8'h05, 16'd0};
    tbl[1] = '{8'd2,   8'd3,   1'b0, 8'd0,   8'h00, 8'hB1, 8'h00, 16'd0};
    tbl[2] = '{8'd10,  8'd10,  1'b1, 8'd10,  8'h7F,
               BYP ? 8'h7F : 8'h00, BYP ? 8'h7F : 8'h00, 16'd0};
    tbl[3] = '{8'd10,  8'd0,   1'b0, 8'd0,   8'h00, 8'h7F, 8'hA0, 16'd1};
    tbl[4] = '{8'd1,   8'd1,   1'b1, 8'd1,   8'h33,
               BYP ? 8'h33 : 8'h05, BYP ? 8'h33 : 8'h05, 16'd1};
    tbl[5] = '{8'd1,   8'd2,   1'b0, 8'd0,   8'h00, 8'h33, 8'hB1, 16'd2};
    tbl[6] = '{8'd255, 8'd10,  1'b1, 8'd200, 8'h55, 8'h00, 8'h7F, 16'd2};
    tbl[7] = '{8'd200, 8'd255, 1'b0, 8'd0,   8'h00, 8'h55, 8'h00, 16'd3};
    tbl[8] = '{8'd5,   8'd10,  1'b1, 8'd5,   8'hAA,
               BYP ? 8'hAA : 8'h00, 8'h7F, 16'd3};
    tbl[9] = '{8'd5,   8'd200, 1'b0, 8'd0,   8'h00, 8'hAA, 8'h55, 16'd4};

    // Values held during reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_ld_count", ld_count, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd1", mem_rd_data1, 0);
    @(negedge clk);
    reset = 1'b0;

    // CLEAR lasts exactly 256 cycles.
    wait_load(n, bad);
    chk("clear_cycles", n, 256);
    chk("clear_cpu_reset_rd", bad, 0);
    chk("load_cpu_reset", cpu_reset, 1);

    // Processor write during LOAD is ignored.
    mem_wr_en   = 1'b1;
    mem_wr_addr = 8'd3;
    mem_wr_data = 8'h5A;
    @(posedge clk);
    #1;
    mem_wr_en = 1'b0;
    chk("load_wr_count", wr_count, 0);

    // Three-byte program with an idle gap and a stray ld_last.
    send(8'hA0, 1'b0);
    ld_last = 1'b1;
    @(posedge clk);
    #1;
    ld_last = 1'b0;
    chk("gap_ld_count", ld_count, 1);
    chk("gap_ld_ready", ld_ready, 1);
    send(8'h05, 1'b0);
    send(8'hB1, 1'b1);
    mem_rd_addr1 = 8'd0;
    #1;
    chk("flush_ld_count", ld_count, 3);
    chk("flush_ld_ready", ld_ready, 0);
    chk("flush_cpu_reset", cpu_reset, 1);
    chk("flush_load_done", load_done, 0);
    chk("flush_rd1", mem_rd_data1, 0);
    @(posedge clk);
    #1;
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_load_done", load_done, 1);

    // RUN-time read/write vectors; reads sampled before the edge.
    for (int i = 0; i < 10; i++) begin
      mem_rd_addr1 = tbl[i].a1;
      mem_rd_addr2 = tbl[i].a2;
      mem_wr_en    = tbl[i].we;
      mem_wr_addr  = tbl[i].wa;
      mem_wr_data  = tbl[i].wd;
      ld_valid     = 1'b1;
      #1;
      chk($sformatf("vec%0d_rd1", i), mem_rd_data1, tbl[i].e1);
      chk($sformatf("vec%0d_rd2", i), mem_rd_data2, tbl[i].e2);
      chk($sformatf("vec%0d_wrc", i), wr_count, tbl[i].ewc);
      chk($sformatf("vec%0d_ldc", i), ld_count, 3);
      @(posedge clk);
      #1;
    end
    mem_wr_en = 1'b0;
    ld_valid  = 1'b0;

    // Full 256-byte load without ld_last.
    do_reset();
    wait_load(n, bad);
    chk("full_clear_cycles", n, 256);
    for (int i = 0; i < 256; i++) begin
      if (!ld_ready) begin
        chk("full_ready_early_drop", i, 256);
        break;
      end
      send(8'(i) ^ 8'hC3, 1'b0);
    end
    chk("full_ld_count", ld_count, 256);
    chk("full_ld_ready", ld_ready, 0);
    send(8'hEE, 1'b0);
    chk("full_257_ld_count", ld_count, 256);
    chk("full_load_done", load_done, 1);
    mem_rd_addr1 = 8'd255;
    mem_rd_addr2 = 8'd0;
    #1;
    chk("full_rd_255", mem_rd_data1, 8'h3C);
    chk("full_rd_0", mem_rd_data2, 8'hC3);
    mem_rd_addr1 = 8'd128;
    #1;
    chk("full_rd_128", mem_rd_data1, 8'h43);

    // Saturating write counter.
    mem_wr_en   = 1'b1;
    mem_wr_addr = 8'd250;
    mem_wr_data = 8'h77;
    repeat (65534) @(posedge clk);
    #1;
    chk("wrc_fffe", wr_count, 16'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    chk("wrc_sat", wr_count, 16'hFFFF);
    mem_wr_en    = 1'b0;
    mem_rd_addr2 = 8'd250;
    #1;
    chk("wrc_rd_250", mem_rd_data2, 8'h77);

    // Reset in the middle of LOAD.
    do_reset();
    wait_load(n, bad);
    chk("mid_clear_cycles", n, 256);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("mid_ld_count_2", ld_count, 2);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_ld_count", ld_count, 0);
    chk("mid_rst_ld_ready", ld_ready, 0);
    chk("mid_rst_cpu_reset", cpu_reset, 1);
    chk("mid_rst_wr_count", wr_count, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_load(n, bad);
    chk("mid_reclear_cycles", n, 256);
    chk("mid_reclear_bad", bad, 0);
    send(8'h00, 1'b1);
    @(posedge clk);
    #1;
    mem_rd_addr1 = 8'd0;
    mem_rd_addr2 = 8'd1;
    #1;
    chk("mid_run_done", load_done, 1);
    chk("mid_rd_0", mem_rd_data1, 8'h00);
    chk("mid_rd_1", mem_rd_data2, 8'h00);
    chk("mid_ld_count_1", ld_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
